// File: rtl/cpu_step_controller.sv
// Debugger step sequencer: gates the CPU clock enable for one cycle, one instruction
// or a free run to a breakpoint, then returns a one-cycle completion pulse.
`timescale 1ns/1ps
module cpu_step_controller #(
  parameter int CYCLE_COUNT_WIDTH = 16,
  parameter int MAX_INSTR_CYCLES  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_start_step,
  input  logic [1:0]                   i_mode,
  input  logic                         i_breakpoint_en,
  input  logic [15:0]                  i_breakpoint_addr,
  input  logic                         i_cpu_sync,
  input  logic [15:0]                  i_cpu_address,
  input  logic                         i_halt,
  output logic                         o_cpu_clk_en,
  output logic                         o_step_completed,
  output logic                         o_busy,
  output logic [CYCLE_COUNT_WIDTH-1:0] o_cycle_count,
  output logic                         o_timeout
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_RUN          = 2'd1;
  localparam logic [1:0] ST_DONE         = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  localparam logic [CYCLE_COUNT_WIDTH-1:0] COUNT_SAT   = '1;
  localparam logic [CYCLE_COUNT_WIDTH-1:0] INSTR_LIMIT = CYCLE_COUNT_WIDTH'(MAX_INSTR_CYCLES);

  logic [1:0]                   state_reg, state_next;
  logic [1:0]                   mode_reg, mode_next;
  logic [CYCLE_COUNT_WIDTH-1:0] count_reg, count_next;
  logic                         timeout_reg, timeout_next;

  logic mode_instr, mode_run, mode_cycle;
  logic count_nonzero, abort;
  logic stop_cycle, stop_sync, stop_limit, stop_halt, stop_bp, stop;

  // Mode 3 decodes as single cycle.
  assign mode_instr    = (mode_reg == 2'd1);
  assign mode_run      = (mode_reg == 2'd2);
  assign mode_cycle    = !mode_instr && !mode_run;
  assign count_nonzero = (count_reg != '0);
  assign abort         = !i_start_step;

  // Sync guards need count!=0 so the fetch the CPU is already parked on is ignored.
  assign stop_cycle = mode_cycle && (count_reg == {{(CYCLE_COUNT_WIDTH-1){1'b0}}, 1'b1});
  assign stop_sync  = mode_instr && count_nonzero && i_cpu_sync;
  assign stop_limit = mode_instr && (count_reg == INSTR_LIMIT);
  assign stop_halt  = mode_run && i_halt;
  assign stop_bp    = mode_run && count_nonzero && i_breakpoint_en && i_cpu_sync &&
                      (i_cpu_address == i_breakpoint_addr);
  assign stop       = abort || stop_cycle || stop_sync || stop_limit || stop_halt || stop_bp;

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    count_next   = count_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start_step) begin
          mode_next    = i_mode;
          count_next   = '0;
          timeout_next = 1'b0;
          state_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_DONE;
          // Timeout only counts when it is the first stop reason.
          if (stop_limit && !abort && !stop_sync)
            timeout_next = 1'b1;
        end else if (count_reg != COUNT_SAT) begin
          count_next = count_reg + 1'b1;
        end
      end
      ST_DONE: state_next = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: begin
        if (!i_start_step)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= 2'd0;
      count_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      count_reg   <= count_next;
      timeout_reg <= timeout_next;
    end
  end

  assign o_cpu_clk_en     = (state_reg == ST_RUN) && !stop;
  assign o_step_completed = (state_reg == ST_DONE);
  assign o_busy           = (state_reg != ST_IDLE);
  assign o_cycle_count    = count_reg;
  assign o_timeout        = timeout_reg;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed steps push expected results into a queue,
// a monitor pops one entry per completion pulse and compares.
`timescale 1ns/1ps
module tb_cpu_step_controller;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_start_step;
  logic [1:0]  i_mode;
  logic        i_breakpoint_en;
  logic [15:0] i_breakpoint_addr;
  logic        i_cpu_sync;
  logic [15:0] i_cpu_address;
  logic        i_halt;
  logic        o_cpu_clk_en;
  logic        o_step_completed;
  logic        o_busy;
  logic [15:0] o_cycle_count;
  logic        o_timeout;

  cpu_step_controller #(
    .CYCLE_COUNT_WIDTH(16),
    .MAX_INSTR_CYCLES (16)
  ) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_start_step     (i_start_step),
    .i_mode           (i_mode),
    .i_breakpoint_en  (i_breakpoint_en),
    .i_breakpoint_addr(i_breakpoint_addr),
    .i_cpu_sync       (i_cpu_sync),
    .i_cpu_address    (i_cpu_address),
    .i_halt           (i_halt),
    .o_cpu_clk_en     (o_cpu_clk_en),
    .o_step_completed (o_step_completed),
    .o_busy           (o_busy),
    .o_cycle_count    (o_cycle_count),
    .o_timeout        (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string name;
    int    count;
    bit    timeout;
    int    en;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int mon_errors = 0;
  int mon_checks = 0;

  // Monitor: samples 2 ns after each falling edge, once the stimulus has settled.
  int en_cnt = 0;
  bit prev_done = 0;
  always @(negedge i_clk) begin
    #2;
    if (!i_reset_n) begin
      en_cnt    = 0;
      prev_done = 0;
    end else begin
      if (o_cpu_clk_en) en_cnt++;
      if (o_step_completed) begin
        mon_checks++;
        if (prev_done) begin
          mon_errors++;
          $display("FAIL pulse_width: completed high 2 cycles, required 1");
        end
        if (exp_q.size() == 0) begin
          mon_checks++;
          mon_errors++;
          $display("FAIL unexpected_completion: count=%0d, required no pulse", o_cycle_count);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          mon_checks += 3;
          if (int'(o_cycle_count) != e.count) begin
            mon_errors++;
            $display("FAIL %s count: got %0d required %0d", e.name, o_cycle_count, e.count);
          end
          if (o_timeout != e.timeout) begin
            mon_errors++;
            $display("FAIL %s timeout: got %0d required %0d", e.name, o_timeout, e.timeout);
          end
          if (en_cnt != e.en) begin
            mon_errors++;
            $display("FAIL %s clk_en_cycles: got %0d required %0d", e.name, en_cnt, e.en);
          end
          $display("step %s: count=%0d timeout=%0d clk_en_cycles=%0d", e.name,
                   o_cycle_count, o_timeout, en_cnt);
        end
        en_cnt = 0;
      end
      prev_done = o_step_completed;
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Called at a falling edge. Inputs are driven each cycle from the visible count,
  // modelling the CPU; a negative *_at value means "never".
  task automatic run_step(input string name, input logic [1:0] mode, input bit sync0,
                          input int sync_at, input bit bp_en, input int addr_at,
                          input int halt_at, input int abort_at, input int exp_count,
                          input bit exp_to, input int exp_en, input bit hold);
    exp_t e;
    bit   done;
    int   cnt;
    e.name = name; e.count = exp_count; e.timeout = exp_to; e.en = exp_en;
    exp_q.push_back(e);
    i_mode          = mode;
    i_breakpoint_en = bp_en;
    i_start_step    = 1'b1;
    done = 0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge i_clk);
      if (o_step_completed) begin
        done = 1;
        if (!hold) i_start_step = 1'b0;
      end else if (o_busy) begin
        cnt           = int'(o_cycle_count);
        i_cpu_sync    = (cnt == sync_at) || (cnt == 0 && sync0);
        i_cpu_address = (cnt == addr_at || cnt == sync_at) ? 16'h8010 : 16'h1000 + o_cycle_count;
        i_halt        = (cnt == halt_at);
        if (cnt == abort_at) i_start_step = 1'b0;
      end
    end
    i_cpu_sync = 1'b0;
    i_halt     = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s no_completion: got none within 100 cycles, required a pulse", name);
    end else if (!hold) begin
      @(negedge i_clk);
      check({name, " busy_after_pulse+1"}, int'(o_busy), 1);
      @(negedge i_clk);
      check({name, " busy_after_pulse+2"}, int'(o_busy), 0);
    end
  endtask

  initial begin
    i_reset_n = 1'b0; i_start_step = 1'b0; i_mode = 2'd0; i_breakpoint_en = 1'b0;
    i_breakpoint_addr = 16'h8010; i_cpu_sync = 1'b0; i_cpu_address = 16'h0000; i_halt = 1'b0;
    repeat (2) @(negedge i_clk);
    check("reset busy", int'(o_busy), 0);
    check("reset clk_en", int'(o_cpu_clk_en), 0);
    check("reset completed", int'(o_step_completed), 0);
    check("reset count", int'(o_cycle_count), 0);
    check("reset timeout", int'(o_timeout), 0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    //        name           mode  s0 sync bp addr halt abort cnt to en hold
    run_step("mode0",        2'd0, 0, -1, 0, -1, -1, -1,   1, 0, 1, 0);
    run_step("mode3",        2'd3, 0, -1, 0, -1, -1, -1,   1, 0, 1, 0);
    run_step("mode1_sync3",  2'd1, 1,  3, 0, -1, -1, -1,   3, 0, 3, 0);
    run_step("mode1_sync1",  2'd1, 1,  1, 0, -1, -1, -1,   1, 0, 1, 0);
    run_step("mode2_bp5",    2'd2, 0,  5, 1,  2, -1, -1,   5, 0, 5, 0);
    run_step("mode2_halt7",  2'd2, 0,  3, 0, -1,  7, -1,   7, 0, 7, 0);
    run_step("mode2_abort4", 2'd2, 0, -1, 0, -1, -1,  4,   4, 0, 4, 0);
    run_step("abort_and_bp", 2'd2, 0,  6, 1, -1, -1,  6,   6, 0, 6, 0);
    run_step("mode1_timeout",2'd1, 1, -1, 0, -1, -1, -1,  16, 1, 16, 1);

    // Request held high after completion: must park without re-running.
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      check("hold busy", int'(o_busy), 1);
      check("hold clk_en", int'(o_cpu_clk_en), 0);
      check("hold completed", int'(o_step_completed), 0);
    end
    i_start_step = 1'b0;
    @(negedge i_clk);
    check("release busy", int'(o_busy), 0);
    check("idle keeps count", int'(o_cycle_count), 16);
    check("idle keeps timeout", int'(o_timeout), 1);
    run_step("rerun_clears", 2'd0, 0, -1, 0, -1, -1, -1,   1, 0, 1, 0);

    // Asynchronous reset in the middle of a mode-2 run.
    i_mode = 2'd2; i_breakpoint_en = 1'b0; i_start_step = 1'b1;
    begin
      bit hit;
      hit = 0;
      for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
        @(negedge i_clk);
        if (o_busy && o_cycle_count == 16'd10) hit = 1;
      end
      check("reach count 10", int'(hit), 1);
    end
    check("pre-reset clk_en", int'(o_cpu_clk_en), 1);
    #3;
    i_reset_n = 1'b0;
    i_start_step = 1'b0;
    i_mode = 2'd0;
    #1;
    check("async clk_en", int'(o_cpu_clk_en), 0);
    check("async busy", int'(o_busy), 0);
    check("async completed", int'(o_step_completed), 0);
    check("async count", int'(o_cycle_count), 0);
    @(negedge i_clk);
    #3;
    i_reset_n = 1'b1;
    @(negedge i_clk);
    run_step("after_reset",  2'd0, 0, -1, 0, -1, -1, -1,   1, 0, 1, 0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge i_clk);
    #3;
    check("scoreboard drained", exp_q.size(), 0);

    errors = errors + mon_errors;
    checks = checks + mon_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
